// File: rtl/serial_pkg.sv
// Shared definitions for the serial deserializer slice: default word length,
// bit-counter width helper and output-buffer state encoding.
package serial_pkg;

    localparam int unsigned DEFAULT_LENGTH = 32;

    // Width able to hold counts 0..n (covers the extra parity slot too).
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/serial_deser_obuf.sv
// One-entry valid/ready holding register for assembled words, with a sticky
// overflow flag raised when a completed word arrives while the entry is held.
module serial_deser_obuf
    import serial_pkg::*;
#(
    parameter int unsigned LENGTH = DEFAULT_LENGTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [LENGTH-1:0] i_word,
    input  logic              i_par_err,
    input  logic              i_load,
    input  logic              i_rdy,
    output logic [LENGTH-1:0] o_word,
    output logic              o_vld,
    output logic              o_ovf,
    output logic              o_par_err
);

    out_state_t state, state_nxt;
    logic       capture;
    logic       set_ovf;

    // Buffer state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= EMPTY;
        else       state <= state_nxt;
    end

    // Next state plus capture/overflow strobes; a simultaneous handshake and
    // completion reloads the entry without a bubble.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        set_ovf   = 1'b0;
        case (state)
            EMPTY: begin
                if (i_load) begin
                    capture   = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (i_load) begin
                    if (i_rdy) capture = 1'b1;
                    else       set_ovf = 1'b1;
                end else if (i_rdy) begin
                    state_nxt = EMPTY;
                end
            end
        endcase
    end

    // Held word, its parity status and the sticky overflow flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_word    <= '0;
            o_par_err <= 1'b0;
            o_ovf     <= 1'b0;
        end else begin
            if (capture) begin
                o_word    <= i_word;
                o_par_err <= i_par_err;
            end
            if (set_ovf) o_ovf <= 1'b1;
        end
    end

    assign o_vld = (state == FULL);

endmodule

// File: rtl/serial_deser.sv
// LSB-first serial-to-parallel deserializer feeding a one-entry valid/ready
// output buffer. Optional feature macro: SERIAL_DESER_PARITY_EN appends an
// even-parity bit to every frame and reports its check on o_par_err.
module serial_deser
    import serial_pkg::*;
#(
    parameter int unsigned LENGTH = DEFAULT_LENGTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_din,
    input  logic              i_din_vld,
    input  logic              i_rdy,
    output logic [LENGTH-1:0] o_word,
    output logic              o_vld,
    output logic              o_ovf,
    output logic              o_par_err
);

    localparam int unsigned CNT_W = cnt_width(LENGTH);

`ifdef SERIAL_DESER_PARITY_EN
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LENGTH);
`else
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LENGTH - 1);
`endif

    logic [LENGTH-1:0] shreg;
    logic [LENGTH-1:0] shift_nxt;
    logic [LENGTH-1:0] word_done;
    logic [CNT_W-1:0]  cnt;
    logic              data_bit;
    logic              complete;
    logic              par_err;

    assign shift_nxt = (shreg >> 1) | (LENGTH'(i_din) << (LENGTH - 1));
    assign complete  = i_din_vld && (cnt == LAST);

`ifdef SERIAL_DESER_PARITY_EN
    // The parity slot is not shifted in, so shreg already holds the word.
    assign data_bit  = (cnt != LAST);
    assign word_done = shreg;
    assign par_err   = (^shreg) ^ i_din;
`else
    // The final bit is merged combinationally so the word is ready on its edge.
    assign data_bit  = 1'b1;
    assign word_done = shift_nxt;
    assign par_err   = 1'b0;
`endif

    // Shift register: new bits enter at the MSB and walk toward bit 0.
    always_ff @(posedge i_clk) begin
        if (i_rst)                       shreg <= '0;
        else if (i_din_vld && data_bit)  shreg <= shift_nxt;
    end

    // Bit counter, wrapping on the completion edge so frames run back-to-back.
    always_ff @(posedge i_clk) begin
        if (i_rst)           cnt <= '0;
        else if (complete)   cnt <= '0;
        else if (i_din_vld)  cnt <= cnt + CNT_W'(1);
    end

    serial_deser_obuf #(
        .LENGTH (LENGTH)
    ) u_obuf (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_word    (word_done),
        .i_par_err (par_err),
        .i_load    (complete),
        .i_rdy     (i_rdy),
        .o_word    (o_word),
        .o_vld     (o_vld),
        .o_ovf     (o_ovf),
        .o_par_err (o_par_err)
    );

endmodule

// File: tb/tb_serial_deser.sv
// Self-checking bench for serial_deser: table-driven frames, hand-written
// overflow / back-to-back / mid-word reset sequences, and random traffic
// checked every cycle against a frame-level reference model.
module tb_serial_deser;
    import serial_pkg::*;

    localparam int unsigned L = DEFAULT_LENGTH;
`ifdef SERIAL_DESER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int unsigned FRAME = L + (PAR_EN ? 1 : 0);

    logic          tb_clk;
    logic          rst;
    logic          din;
    logic          din_vld;
    logic          rdy;
    logic [L-1:0]  word;
    logic          vld;
    logic          ovf;
    logic          par_err;

    int n_tests = 0;
    int n_fail  = 0;

    serial_deser #(
        .LENGTH (L)
    ) dut (
        .i_clk     (tb_clk),
        .i_rst     (rst),
        .i_din     (din),
        .i_din_vld (din_vld),
        .i_rdy     (rdy),
        .o_word    (word),
        .o_vld     (vld),
        .o_ovf     (ovf),
        .o_par_err (par_err)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Reference model: collected bits of the current frame plus buffer contents.
    bit           mq[$];
    logic         m_vld;
    logic [L-1:0] m_word;
    logic         m_ovf;
    logic         m_perr;

    function automatic void model_edge(input logic d, input logic dv, input logic r, input logic rs);
        logic         done;
        logic [L-1:0] w;
        logic         pe;
        done = 1'b0;
        w    = '0;
        pe   = 1'b0;
        if (rs) begin
            mq.delete();
            m_vld  = 1'b0;
            m_word = '0;
            m_ovf  = 1'b0;
            m_perr = 1'b0;
            return;
        end
        if (dv) begin
            mq.push_back(d);
            if (mq.size() == FRAME) begin
                done = 1'b1;
                for (int i = 0; i < int'(L); i++) w[i] = mq[i];
                for (int i = 0; i < int'(FRAME); i++) pe ^= mq[i];
                mq.delete();
            end
        end
        if (m_vld) begin
            if (done) begin
                if (r) begin
                    m_word = w;
                    m_perr = PAR_EN ? pe : 1'b0;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (r) begin
                m_vld = 1'b0;
            end
        end else if (done) begin
            m_vld  = 1'b1;
            m_word = w;
            m_perr = PAR_EN ? pe : 1'b0;
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    int   fr_edges;
    int   fr_rise;
    logic any_low;
    logic prev_vld;

    task automatic step(input logic d, input logic dv, input logic r, input logic rs);
        din      = d;
        din_vld  = dv;
        rdy      = r;
        rst      = rs;
        prev_vld = vld;
        @(posedge tb_clk);
        model_edge(d, dv, r, rs);
        #1;
        chk("model_vld", 64'(vld), 64'(m_vld));
        chk("model_ovf", 64'(ovf), 64'(m_ovf));
        if (m_vld) begin
            chk("model_word", 64'(word), 64'(m_word));
            chk("model_par_err", 64'(par_err), 64'(m_perr));
        end
        if (vld !== 1'b1) any_low = 1'b1;
        fr_edges++;
        if (vld === 1'b1 && prev_vld !== 1'b1 && fr_rise == 0) fr_rise = fr_edges;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_vld", 64'(vld), 64'd0);
        chk("rst_word", 64'(word), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_par_err", 64'(par_err), 64'd0);
    endtask

    task automatic send_frame(input logic [L-1:0] w, input bit gap, input logic r_body,
                              input logic r_last, input logic pbit);
        fr_edges = 0;
        fr_rise  = 0;
        any_low  = 1'b0;
        for (int unsigned i = 0; i < FRAME; i++) begin
            logic b;
            logic last;
            b    = (i < L) ? w[i] : pbit;
            last = (i == FRAME - 1);
            step(b, 1'b1, last ? r_last : r_body, 1'b0);
            if (gap && !last) step(1'($urandom_range(0, 1)), 1'b0, r_body, 1'b0);
        end
    endtask

    typedef struct {
        logic [L-1:0] word;
        bit           gap;
        logic [L-1:0] exp_word;
        int           exp_rise;
    } vec_t;

    vec_t vt[6];

    initial begin
        din     = 1'b0;
        din_vld = 1'b0;
        rdy     = 1'b0;
        rst     = 1'b1;

        vt[0] = '{32'hA5A51234, 1'b0, 32'hA5A51234, int'(FRAME)};
        vt[1] = '{32'hA5A51234, 1'b1, 32'hA5A51234, int'(2 * FRAME - 1)};
        vt[2] = '{32'hDEADBEEF, 1'b0, 32'hDEADBEEF, int'(FRAME)};
        vt[3] = '{32'h00000000, 1'b0, 32'h00000000, int'(FRAME)};
        vt[4] = '{32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, int'(2 * FRAME - 1)};
        vt[5] = '{32'h80000001, 1'b0, 32'h80000001, int'(FRAME)};

        // Single frames with even parity, ready held high.
        foreach (vt[k]) begin
            do_reset();
            send_frame(vt[k].word, vt[k].gap, 1'b1, 1'b1, ^vt[k].word);
            chk($sformatf("tbl%0d_rise", k), 64'(fr_rise), 64'(vt[k].exp_rise));
            chk($sformatf("tbl%0d_word", k), 64'(word), 64'(vt[k].exp_word));
            chk($sformatf("tbl%0d_ovf", k), 64'(ovf), 64'd0);
            chk($sformatf("tbl%0d_par_err", k), 64'(par_err), 64'd0);
            step(1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("tbl%0d_vld_one_cycle", k), 64'(vld), 64'd0);
        end

        // Overflow: second word dropped while downstream stalls.
        do_reset();
        send_frame(32'h0000FFFF, 1'b0, 1'b0, 1'b0, ^32'h0000FFFF);
        chk("ovf_first_vld", 64'(vld), 64'd1);
        chk("ovf_first_word", 64'(word), 64'h0000FFFF);
        chk("ovf_first_flag", 64'(ovf), 64'd0);
        send_frame(32'h12345678, 1'b0, 1'b0, 1'b0, ^32'h12345678);
        chk("ovf_flag", 64'(ovf), 64'd1);
        chk("ovf_word_kept", 64'(word), 64'h0000FFFF);
        chk("ovf_vld_kept", 64'(vld), 64'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf_drain_vld", 64'(vld), 64'd0);
        chk("ovf_sticky", 64'(ovf), 64'd1);

        // Handshake on the same edge as the next completion: no bubble, no overflow.
        do_reset();
        send_frame(32'hCAFEF00D, 1'b0, 1'b0, 1'b0, ^32'hCAFEF00D);
        chk("b2b_first_word", 64'(word), 64'hCAFEF00D);
        send_frame(32'h0BADBEEF, 1'b0, 1'b0, 1'b1, ^32'h0BADBEEF);
        chk("b2b_no_bubble", 64'(any_low), 64'd0);
        chk("b2b_word", 64'(word), 64'h0BADBEEF);
        chk("b2b_ovf", 64'(ovf), 64'd0);
        chk("b2b_vld", 64'(vld), 64'd1);

        // Reset in the middle of a frame discards the partial word.
        do_reset();
        send_frame(32'h5555AAAA, 1'b0, 1'b0, 1'b0, ^32'h5555AAAA);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        send_frame(32'hDEADBEEF, 1'b0, 1'b1, 1'b1, ^32'hDEADBEEF);
        chk("midrst_rise", 64'(fr_rise), 64'(FRAME));
        chk("midrst_word", 64'(word), 64'hDEADBEEF);

`ifdef SERIAL_DESER_PARITY_EN
        do_reset();
        send_frame(32'h00000001, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("par_good_rise", 64'(fr_rise), 64'd33);
        chk("par_good_err", 64'(par_err), 64'd0);
        chk("par_good_word", 64'(word), 64'h00000001);
        send_frame(32'h00000001, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("par_bad_rise", 64'(fr_rise), 64'd33);
        chk("par_bad_err", 64'(par_err), 64'd1);
        chk("par_bad_word", 64'(word), 64'h00000001);
`endif

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 399) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
